// File: rtl/prc_sched.sv
// prc_sched: partial-reconfiguration request scheduler.
//
// Grants one requester at a time, round-robin. For the granted requester it
// isolates and resets the user region, starts the config load, waits for
// done / error / timeout, holds the region in reset for a fixed time,
// then returns a status and raises a level interrupt on failure.
//
// Ports
//   clk          single clock
//   reset        synchronous, active-high
//   req          per-requester level request, held until its rsp_valid
//   grant        one-hot owner, zero when idle
//   rsp_valid    one-cycle completion pulse
//   rsp_status   00 ok, 01 cfg error, 10 timeout; held until next rsp_valid
//   cfg_start    one-cycle load start pulse
//   cfg_done     load-complete pulse (synchronized)
//   cfg_err      load-error level or pulse (synchronized)
//   decouple     isolates the user-region interfaces
//   rp_resetn    active-low user-region reset
//   busy         high whenever not IDLE
//   err_int_req  level interrupt, set on a failed load
//   err_int_ack  clears err_int_req (a coincident set wins)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner; pick next requester at/after rr_ptr
// DECOUPLE | region isolated and in reset, DECOUPLE_CYC cycles
// START    | one-cycle cfg_start pulse, timeout timer loaded
// BUSY     | waiting for cfg_err / cfg_done / timeout
// RELEASE  | region still in reset, RST_CYC cycles
// RESP     | rsp_valid pulse, advance rr_ptr, raise interrupt on error

module prc_sched #(
    parameter int                    NUM_REQ      = 4,
    parameter int                    DECOUPLE_CYC = 16,
    parameter int                    RST_CYC      = 32,
    parameter int                    TO_WIDTH     = 28,
    parameter logic [TO_WIDTH-1:0]   TIMEOUT      = 28'h100_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               rsp_valid,
    output logic [1:0]         rsp_status,
    output logic               cfg_start,
    input  logic               cfg_done,
    input  logic               cfg_err,
    output logic               decouple,
    output logic               rp_resetn,
    output logic               busy,
    output logic               err_int_req,
    input  logic               err_int_ack
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (DECOUPLE_CYC > RST_CYC) ? DECOUPLE_CYC : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    DEC_LOAD  = CNT_W'(DECOUPLE_CYC - 1);
    localparam logic [CNT_W-1:0]    RST_LOAD  = CNT_W'(RST_CYC - 1);
    localparam logic [TO_WIDTH-1:0] TO_LOAD   = TIMEOUT - 1'b1;
    localparam logic [IDX_W:0]      NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CFG_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECOUPLE,
        S_START,
        S_BUSY,
        S_RELEASE,
        S_RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [TO_WIDTH-1:0] to_cnt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic [1:0]          status_q;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W:0]      pick_sum;

    logic                busy_exit;

    // Round-robin search: first set req bit at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (pick_sum >= NUM_REQ_W) begin
                pick_sum = pick_sum - NUM_REQ_W;
            end
            if (!pick_found && req[pick_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_sum[IDX_W-1:0];
            end
        end
    end

    assign busy_exit = cfg_err || cfg_done || (to_cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (pick_found) state_nxt = S_DECOUPLE;
            S_DECOUPLE: if (cnt == '0)  state_nxt = S_START;
            S_START:                    state_nxt = S_BUSY;
            S_BUSY:     if (busy_exit)  state_nxt = S_RELEASE;
            S_RELEASE:  if (cnt == '0)  state_nxt = S_RESP;
            S_RESP:                     state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timers count down to zero; the load value is the cycle count minus one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            to_cnt     <= '0;
            grant      <= '0;
            grant_idx  <= '0;
            rr_ptr     <= '0;
            status_q   <= ST_OK;
            rsp_status <= ST_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant     <= NUM_REQ'(1) << pick_idx;
                        grant_idx <= pick_idx;
                        cnt       <= DEC_LOAD;
                    end
                end
                S_DECOUPLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_START: begin
                    to_cnt <= TO_LOAD;
                end
                S_BUSY: begin
                    if (cfg_err) begin
                        status_q <= ST_CFG_ERR;
                    end else if (cfg_done) begin
                        status_q <= ST_OK;
                    end else if (to_cnt == '0) begin
                        status_q <= ST_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                    if (busy_exit) cnt <= RST_LOAD;
                end
                S_RELEASE: begin
                    // rsp_status only changes as RESP is entered so it stays
                    // stable between responses.
                    if (cnt == '0) begin
                        rsp_status <= status_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    grant  <= '0;
                    rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_int_req <= 1'b0;
        end else if (state == S_RESP && rsp_status != ST_OK) begin
            err_int_req <= 1'b1;
        end else if (err_int_ack) begin
            err_int_req <= 1'b0;
        end
    end

    assign busy      = (state != S_IDLE);
    assign decouple  = (state != S_IDLE);
    assign rp_resetn = (state == S_IDLE);
    assign cfg_start = (state == S_START);
    assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_prc_sched.sv
module tb_prc_sched;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic          cfg_start;
    logic          cfg_done;
    logic          cfg_err;
    logic          decouple;
    logic          rp_resetn;
    logic          busy;
    logic          err_int_req;
    logic          err_int_ack;

    prc_sched #(
        .NUM_REQ     (NR),
        .DECOUPLE_CYC(4),
        .RST_CYC     (8),
        .TO_WIDTH    (28),
        .TIMEOUT     (28'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .cfg_start  (cfg_start),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .decouple   (decouple),
        .rp_resetn  (rp_resetn),
        .busy       (busy),
        .err_int_req(err_int_req),
        .err_int_ack(err_int_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] sb[$];    // {grant, status}

    localparam int M_DONE = 0, M_ERR = 1, M_NONE = 2, M_BOTH = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                chk("rsp grant", 32'(grant), 32'(e[5:2]));
                chk("rsp status", 32'(rsp_status), 32'(e[1:0]));
            end
        end
    end

    // Length of the most recent rp_resetn-low run.
    int low_run = 0;
    int last_low = 0;
    always @(negedge clk) begin
        if (rp_resetn === 1'b0) begin
            low_run++;
        end else if (low_run != 0) begin
            last_low = low_run;
            low_run  = 0;
        end
    end

    // From the cfg_start negedge: drive the load result so it is sampled in
    // BUSY cycle k, then wait for the response. lat = negedges from cfg_start
    // to rsp_valid.
    task automatic finish_op(input int k, input int mode, input logic ack_rsp,
                             input logic [NR-1:0] req_after, output int lat);
        lat = 0;
        if (mode != M_NONE) begin
            repeat (k) @(negedge clk);
            cfg_done = (mode == M_DONE || mode == M_BOTH);
            cfg_err  = (mode == M_ERR  || mode == M_BOTH);
            @(negedge clk);
            cfg_done = 1'b0;
            cfg_err  = 1'b0;
            lat = k + 1;
        end
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid seen", 32'(rsp_valid), 32'd1);
        chk("decouple in RESP", 32'(decouple), 32'd1);
        chk("rp_resetn in RESP", 32'(rp_resetn), 32'd0);
        req         = req_after;
        err_int_ack = ack_rsp;
        if (ack_rsp) begin
            @(negedge clk);
            err_int_ack = 1'b0;
        end
    endtask

    task automatic wait_start(input logic [NR-1:0] eg, output int n);
        n = 0;
        while (cfg_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_start seen", 32'(cfg_start), 32'd1);
        chk("grant", 32'(grant), 32'(eg));
    endtask

    task automatic do_op(input logic [NR-1:0] eg, input int k, input int mode,
                         input logic [1:0] es, input logic ack_rsp,
                         input logic [NR-1:0] req_after, output int lat);
        int n;
        sb.push_back({eg, es});
        wait_start(eg, n);
        finish_op(k, mode, ack_rsp, req_after, lat);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " grant"}, 32'(grant), 32'd0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, " cfg_start"}, 32'(cfg_start), 32'd0);
        chk({tag, " decouple"}, 32'(decouple), 32'd0);
        chk({tag, " rp_resetn"}, 32'(rp_resetn), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " err_int_req"}, 32'(err_int_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] rr_grant [7];
        logic [NR-1:0] rr_after [7];
        int lat;
        int n;

        reset = 1'b1; req = '0; cfg_done = 1'b0; cfg_err = 1'b0; err_int_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single request, done in BUSY cycle 11.
        req = 4'b0010;
        sb.push_back({4'b0010, 2'b00});
        @(negedge clk);
        chk("t1 grant", 32'(grant), 32'b0010);
        chk("t1 busy", 32'(busy), 32'd1);
        chk("t1 decouple", 32'(decouple), 32'd1);
        chk("t1 rp_resetn", 32'(rp_resetn), 32'd0);
        n = 0;
        while (cfg_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1 cfg_start lag", 32'(n), 32'd4);
        finish_op(11, M_DONE, 1'b0, 4'b0000, lat);
        chk("t1 rsp latency", 32'(lat), 32'd20);
        @(negedge clk);
        chk("t1 idle grant", 32'(grant), 32'd0);
        chk("t1 idle busy", 32'(busy), 32'd0);
        chk("t1 idle rp_resetn", 32'(rp_resetn), 32'd1);
        chk("t1 err_int_req", 32'(err_int_req), 32'd0);
        @(negedge clk);
        chk("t1 rp_resetn low len", 32'(last_low), 32'd25);

        // Round robin with all requests held, then a changed request set.
        do_reset();
        rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rr_after = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1001, 4'b0000};
        req = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            do_op(rr_grant[i], 5, M_DONE, 2'b00, 1'b0, rr_after[i], lat);
        end

        // cfg errors and the interrupt; rr_ptr is 0 here.
        req = 4'b0100;
        do_op(4'b0100, 3, M_ERR, 2'b01, 1'b0, 4'b0000, lat);
        @(negedge clk);
        chk("err int set", 32'(err_int_req), 32'd1);
        repeat (5) @(negedge clk);
        chk("err int held", 32'(err_int_req), 32'd1);
        req = 4'b0001;
        do_op(4'b0001, 3, M_ERR, 2'b01, 1'b1, 4'b0000, lat);
        chk("err int set beats ack", 32'(err_int_req), 32'd1);
        err_int_ack = 1'b1;
        @(negedge clk);
        err_int_ack = 1'b0;
        chk("err int cleared", 32'(err_int_req), 32'd0);

        // Timeout, done on the last BUSY cycle, err+done together.
        req = 4'b1000;
        do_op(4'b1000, 0, M_NONE, 2'b10, 1'b0, 4'b0000, lat);
        chk("timeout latency", 32'(lat), 32'd109);
        @(negedge clk);
        chk("timeout err int", 32'(err_int_req), 32'd1);
        err_int_ack = 1'b1;
        @(negedge clk);
        err_int_ack = 1'b0;
        req = 4'b0001;
        do_op(4'b0001, 100, M_DONE, 2'b00, 1'b0, 4'b0000, lat);
        chk("done@100 latency", 32'(lat), 32'd109);
        @(negedge clk);
        chk("done@100 err int", 32'(err_int_req), 32'd0);
        req = 4'b0010;
        do_op(4'b0010, 3, M_BOTH, 2'b01, 1'b0, 4'b0000, lat);

        // Reset in BUSY (rr_ptr=2, err_int_req=1, rsp_status=01 beforehand).
        req = 4'b0100;
        wait_start(4'b0100, n);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst busy");
        reset = 1'b0;
        req = 4'b1111;
        do_op(4'b0001, 2, M_DONE, 2'b00, 1'b0, 4'b0000, lat);

        // Reset in RELEASE (rr_ptr=1 beforehand).
        req = 4'b1000;
        wait_start(4'b1000, n);
        @(negedge clk);
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst release");
        reset = 1'b0;
        req = 4'b1001;
        do_op(4'b0001, 2, M_DONE, 2'b00, 1'b0, 4'b0000, lat);

        // cfg_done/cfg_err ignored in IDLE and DECOUPLE (rr_ptr=1).
        @(negedge clk);
        cfg_done = 1'b1;
        cfg_err  = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        chk("idle pulse busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle pulse busy2", 32'(busy), 32'd0);
        req = 4'b0100;
        @(negedge clk);
        cfg_done = 1'b1;
        cfg_err  = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        do_op(4'b0100, 2, M_DONE, 2'b00, 1'b0, 4'b0000, lat);
        @(negedge clk);
        chk("decouple pulse err int", 32'(err_int_req), 32'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
